// File: rtl/axis_gen_pkg.sv
// Shared types and helpers for the AXI-Stream packet generator.
// Holds the FSM state encoding, lane-index sizing and the contiguous tkeep mask builder.
package axis_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DONE
  } state_t;

  localparam int MAX_LANES      = 64;
  localparam int DEF_AXIS_BYTES = 4;

  function automatic int lane_idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  localparam int DEF_LANE_IDX_W = lane_idx_w(DEF_AXIS_BYTES);

  // rem==0 means the final beat is full, so every lane is enabled.
  function automatic logic [MAX_LANES-1:0] keep_mask(input int rem, input int lanes);
    int                   n;
    logic [MAX_LANES-1:0] m;
    n = (rem == 0) ? lanes : rem;
    m = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/axis_beats_generator_keep.sv
// Combinational last-beat byte-enable mask: low rem_i lanes set, all lanes when rem_i is zero.
module axis_keep_mask
  import axis_gen_pkg::*;
#(
  parameter  int LANES = 4,
  localparam int LW    = lane_idx_w(LANES)
) (
  input  logic [LW-1:0]    rem_i,
  output logic [LANES-1:0] keep_o
);

  always_comb begin
    keep_o = LANES'(keep_mask((LANES == 1) ? 0 : int'(rem_i), LANES));
  end

endmodule

// File: rtl/axis_beats_generator.sv
// AXI-Stream packet source: accepts (len, seed) and emits len incrementing bytes as one packet.
// Beats are built one cycle ahead into a registered output stage that holds while stalled.
module axis_beats_generator
  import axis_gen_pkg::*;
#(
  parameter int AXIS_BYTES   = 4,
  parameter int COUNTER_BITS = 32
) (
  input  logic                      aclk,
  input  logic                      rst,
  input  logic                      s_cmd_tvalid,
  output logic                      s_cmd_tready,
  input  logic [COUNTER_BITS-1:0]   s_cmd_len,
  input  logic [7:0]                s_cmd_seed,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [AXIS_BYTES*8-1:0]   m_axis_tdata,
  output logic [AXIS_BYTES-1:0]     m_axis_tkeep,
  output logic [COUNTER_BITS-1:0]   bytes_sent,
  output logic                      done
);

  localparam int                      LW         = lane_idx_w(AXIS_BYTES);
  localparam int                      DW         = AXIS_BYTES * 8;
  localparam logic [COUNTER_BITS-1:0] BEAT_BYTES = COUNTER_BITS'(AXIS_BYTES);

  state_t                  state_q;
  logic [COUNTER_BITS-1:0] rem_q, bytes_q;
  logic [7:0]              seed_q;
  logic                    tvalid_q, tlast_q;
  logic [DW-1:0]           tdata_q;
  logic [AXIS_BYTES-1:0]   tkeep_q;

  logic                    cmd_acc, beat_hs, last_d;
  logic [COUNTER_BITS-1:0] src_rem, rem_d, sent_inc;
  logic [7:0]              src_seed, seed_d;
  logic [DW-1:0]           dat_d;
  logic [AXIS_BYTES-1:0]   keep_d, last_keep;

  assign s_cmd_tready = (state_q == ST_IDLE) && !rst;
  assign cmd_acc      = s_cmd_tvalid && s_cmd_tready;
  assign beat_hs      = tvalid_q && m_axis_tready;

  // Next beat comes from the command on accept, otherwise from the running counters.
  always_comb begin
    src_rem  = cmd_acc ? s_cmd_len  : rem_q;
    src_seed = cmd_acc ? s_cmd_seed : seed_q;
    last_d   = (src_rem <= BEAT_BYTES);
    rem_d    = last_d ? '0 : (src_rem - BEAT_BYTES);
    seed_d   = src_seed + 8'(AXIS_BYTES);
    dat_d    = '0;
    for (int i = 0; i < AXIS_BYTES; i++) begin
      if (COUNTER_BITS'(i) < src_rem) dat_d[i*8 +: 8] = src_seed + 8'(i);
    end
    keep_d   = last_d ? last_keep : '1;
    sent_inc = '0;
    for (int i = 0; i < AXIS_BYTES; i++) begin
      sent_inc = sent_inc + COUNTER_BITS'(tkeep_q[i]);
    end
  end

  axis_keep_mask #(.LANES(AXIS_BYTES)) u_keep (
    .rem_i  (src_rem[LW-1:0]),
    .keep_o (last_keep)
  );

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      seed_q   <= '0;
      bytes_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_acc) begin
            bytes_q <= '0;
            if (s_cmd_len == '0) begin
              state_q <= ST_DONE;
            end else begin
              state_q  <= ST_SEND;
              tvalid_q <= 1'b1;
              tdata_q  <= dat_d;
              tkeep_q  <= keep_d;
              tlast_q  <= last_d;
              rem_q    <= rem_d;
              seed_q   <= seed_d;
            end
          end
        end
        ST_SEND: begin
          if (beat_hs) begin
            bytes_q <= bytes_q + sent_inc;
            if (tlast_q) begin
              state_q  <= ST_DONE;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              tdata_q  <= '0;
              tkeep_q  <= '0;
            end else begin
              tdata_q <= dat_d;
              tkeep_q <= keep_d;
              tlast_q <= last_d;
              rem_q   <= rem_d;
              seed_q  <= seed_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign bytes_sent    = bytes_q;
  assign done          = (state_q == ST_DONE);

endmodule
